shift_window_ctrl: RTL and testbench
====================================

# shift_window_ctrl

Sequencing controller for the sample shift register (`DATA_SIZE`-bit words, `DEPTH` taps, shifted on the rising edge of its strobe). It accepts samples from upstream over a valid/ready handshake and drives the register's shift strobe and data as clean single-cycle pulses. It tracks how many fresh samples the register holds and presents a window-valid handshake to the consumer every `STRIDE` samples once the register is full. The shift register has no reset, so this block is the only authority on whether its parallel output is meaningful.

## Interface
- `DATA_SIZE`, 8, sample width.
- `DEPTH`, 4, shift register depth; must be ≥2.
- `STRIDE`, 1, samples between consecutive windows once full; must be ≥1.
- `FILL_W`, derived, clog2(`DEPTH`+1).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous flush of fill/stride tracking.
- `in_valid`  in  1  upstream sample valid.
- `in_data`  in  `DATA_SIZE`  upstream sample.
- `in_ready`  out  1  sample can be accepted this cycle.
- `shift_en`  out  1  strobe to the shift register's `ready` input.
- `shift_data`  out  `DATA_SIZE`  to the shift register's `data_in`.
- `win_valid`  out  1  register output is a valid, stable window.
- `win_ready`  in  1  consumer has taken the window.
- `fill`  out  `FILL_W`  fresh samples held, saturates at `DEPTH`.
- `win_cnt`  out  16  windows issued; wraps at 0xFFFF→0.

## Operation
- States: `READY`, `SHIFT`, `PRESENT`. Reset state is `READY`.
- `in_ready` is combinational: (state==`READY`) & ~`clear`.
- Accept means `in_valid & in_ready` at a rising edge. It loads `shift_data`←`in_data` and moves to `SHIFT`.
- `SHIFT` lasts exactly one cycle with `shift_en`=1.
  - `fill` increments, saturating at `DEPTH`.
  - `stride_cnt` increments.
- After `SHIFT`, if new `fill`==`DEPTH` and (this is the first full window, or `stride_cnt`==`STRIDE`), go to `PRESENT` and clear `stride_cnt`. Otherwise go to `READY`.
- `PRESENT`: `win_valid`=1 and `in_ready`=0, so the window stays frozen.
  - On `win_ready`=1, `win_cnt` increments and the state goes to `READY`.
- `shift_data` holds its value until the next accept. It is stable before, during and after the strobe.
- `shift_en` is registered and never high two cycles in a row. The datapath always sees a low→high edge per sample.
- `clear`=1 at an edge, from any state:
  - next state is `READY`; `fill` and `stride_cnt` go to 0; `win_valid` and `shift_en` go to 0.
  - `shift_data` and `win_cnt` are kept.
  - A sample strobed in the same cycle is counted as discarded.
- Reset values: `in_ready`=1 once `rst_n` is high (and `clear` is low). `shift_en`=0, `shift_data`=0, `win_valid`=0, `fill`=0, `win_cnt`=0, `stride_cnt`=0.
- `rst_n` low clears everything asynchronously, including mid-`SHIFT` (the strobe drops immediately) and mid-`PRESENT`.

## Timing
- Accept at edge 0 → `shift_en` high in cycle 1 → `win_valid` high from cycle 2 if the window is due.
- Maximum throughput without backpressure is one sample per 2 cycles.
- Window issue costs at least 1 extra cycle (`PRESENT` with `win_ready` held at 1).
- `win_ready` high while `win_valid` is low is ignored.
- `clear` and `win_ready` in the same cycle: `clear` wins and `win_cnt` does not increment.

## Structure
- Shared package `shift_window_pkg`:
  - state enum `win_state_t` {`READY`, `SHIFT`, `PRESENT`};
  - function `clog2`;
  - constant `WIN_CNT_W`=16.
- One natural sub-module: `sat_counter` (parameterised width and max, with inc/clr), used for `fill`.
- `stride_cnt` and `win_cnt` are inline.
- A separate wrapper instantiates this block together with the existing shift register; this block does not instantiate it.

## Test plan
- Defaults for all scenarios: `DEPTH`=4, `STRIDE`=2, `DATA_SIZE`=8, reference model of the shift register attached.
- Reset, `win_ready`=1, `in_valid` held with 0x11,0x22,0x33,0x44:
  - `shift_en` pulses in cycles 1,3,5,7;
  - `fill` goes 1,2,3,4;
  - `win_valid` in cycle 8 with window {0x44,0x33,0x22,0x11}; `win_cnt`=1.
- Stride: continue with 0x55, then 0x66 → no window after 0x55; window {0x66,0x55,0x44,0x33} after 0x66; `win_cnt`=2.
- Backpressure: `win_ready`=0 for 5 cycles during `PRESENT`:
  - `win_valid` held, `in_ready`=0, no `shift_en`, window unchanged;
  - accept resumes the cycle after `win_ready` returns.
- `clear` during `PRESENT` → `win_valid` low next cycle and `fill`=0. The next window appears only after 4 new samples; the first of those issues regardless of stride.
- `clear` and `in_valid` in the same `READY` cycle → no accept, no `shift_en`, `shift_data` unchanged.
- `rst_n` low during `SHIFT` → `shift_en`, `fill`, `win_cnt` and `shift_data` go to 0 without waiting for a clock edge. After release, `in_ready`=1.

Source files
------------

// File: rtl/shift_window_pkg.sv
// Shared types and helpers for the shift-register window controller.
package shift_window_pkg;

    localparam int unsigned WIN_CNT_W = 16;

    typedef enum logic [1:0] {
        READY,
        SHIFT,
        PRESENT
    } win_state_t;

    // Ceiling log2; constant-evaluable for port and counter widths.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_window_ctrl_if.sv
// Sample-in / strobe-out / window handshake bundle of the window controller.
interface shift_window_ctrl_if #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned DEPTH     = 4
) ();
    import shift_window_pkg::*;

    localparam int unsigned FILL_W = clog2(DEPTH + 1);

    logic                 clear;
    logic                 in_valid;
    logic [DATA_SIZE-1:0] in_data;
    logic                 in_ready;
    logic                 shift_en;
    logic [DATA_SIZE-1:0] shift_data;
    logic                 win_valid;
    logic                 win_ready;
    logic [FILL_W-1:0]    fill;
    logic [WIN_CNT_W-1:0] win_cnt;

    modport master (
        output clear, in_valid, in_data, win_ready,
        input  in_ready, shift_en, shift_data, win_valid, fill, win_cnt
    );

    modport slave (
        input  clear, in_valid, in_data, win_ready,
        output in_ready, shift_en, shift_data, win_valid, fill, win_cnt
    );

endinterface

// File: rtl/shift_window_ctrl_sat_counter.sv
// Up-counter with synchronous clear that holds at MAX instead of wrapping.
module sat_counter
    import shift_window_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MAX   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/shift_window_ctrl.sv
// Sequences samples into the reset-less shift register and flags when its
// parallel output is a complete, stable window for the consumer.
module shift_window_ctrl
    import shift_window_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned STRIDE    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_window_ctrl_if.slave bus
);

    localparam int unsigned FILL_W   = clog2(DEPTH + 1);
    localparam int unsigned STRIDE_W = clog2(STRIDE + 1);
    localparam logic [FILL_W-1:0]   FULL       = FILL_W'(DEPTH);
    localparam logic [STRIDE_W-1:0] STRIDE_MAX = STRIDE_W'(STRIDE);

    win_state_t           state;
    logic                 shift_en;
    logic [DATA_SIZE-1:0] shift_data;
    logic                 win_valid;
    logic [WIN_CNT_W-1:0] win_cnt;
    logic [STRIDE_W-1:0]  stride_cnt;
    logic [STRIDE_W-1:0]  stride_inc;
    logic [FILL_W-1:0]    fill;
    logic                 fill_inc;
    logic                 becomes_full;
    logic                 first_full;
    logic                 win_due;

    assign bus.in_ready   = (state == READY) && !bus.clear;
    assign bus.shift_en   = shift_en;
    assign bus.shift_data = shift_data;
    assign bus.win_valid  = win_valid;
    assign bus.win_cnt    = win_cnt;
    assign bus.fill       = fill;

    // A strobe cancelled by clear in the same cycle is not counted as fresh.
    assign fill_inc = (state == SHIFT) && !bus.clear;

    sat_counter #(
        .WIDTH (FILL_W),
        .MAX   (DEPTH)
    ) u_fill (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fill_inc),
        .clr   (bus.clear),
        .count (fill)
    );

    // stride_cnt holds at STRIDE while filling; the first full window clears it.
    assign stride_inc   = (stride_cnt == STRIDE_MAX) ? stride_cnt : stride_cnt + 1'b1;
    assign becomes_full = (fill >= FULL - 1'b1);
    assign first_full   = (fill != FULL);
    assign win_due      = becomes_full && (first_full || (stride_inc == STRIDE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= READY;
            shift_en   <= 1'b0;
            shift_data <= '0;
            win_valid  <= 1'b0;
            stride_cnt <= '0;
            win_cnt    <= '0;
        end else if (bus.clear) begin
            state      <= READY;
            shift_en   <= 1'b0;
            win_valid  <= 1'b0;
            stride_cnt <= '0;
        end else begin
            unique case (state)
                READY: begin
                    if (bus.in_valid) begin
                        shift_data <= bus.in_data;
                        shift_en   <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_en <= 1'b0;
                    if (win_due) begin
                        stride_cnt <= '0;
                        win_valid  <= 1'b1;
                        state      <= PRESENT;
                    end else begin
                        stride_cnt <= stride_inc;
                        state      <= READY;
                    end
                end
                PRESENT: begin
                    if (bus.win_ready) begin
                        win_valid <= 1'b0;
                        win_cnt   <= win_cnt + 1'b1;
                        state     <= READY;
                    end
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_window_ctrl.sv
// Directed plus randomized bench for shift_window_ctrl with a shift-register model attached.
module tb_shift_window_ctrl;
    import shift_window_pkg::*;

    localparam int unsigned DW     = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STRIDE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_window_ctrl_if #(.DATA_SIZE(DW), .DEPTH(DEPTH)) bus ();

    shift_window_ctrl #(
        .DATA_SIZE (DW),
        .DEPTH     (DEPTH),
        .STRIDE    (STRIDE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: shifts on each rising edge of the strobe, tap 0 newest.
    logic [DW-1:0] sr [DEPTH];
    logic          prev_se = 1'b0;
    // Transaction-level reference: accepted samples and window bookkeeping.
    logic [DW-1:0] hist[$];
    int            m_fill = 0;
    int            m_since = 0;
    int            m_wins = 0;
    bit            m_first = 1'b1;
    bit            last_due = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.shift_en && !prev_se) begin
                for (int i = DEPTH - 1; i > 0; i--) sr[i] = sr[i-1];
                sr[0] = bus.shift_data;
            end
            chk("shift_en_back_to_back", {31'b0, bus.shift_en & prev_se}, 32'd0);
        end
        prev_se = bus.shift_en;
    end

    task automatic check_window();
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("window_tap%0d", i), sr[i], hist[hist.size() - 1 - i]);
        end
    endtask

    task automatic model_clear();
        m_fill = 0;
        m_since = 0;
        m_first = 1'b1;
    endtask

    // Called at a negedge. Returns at the negedge two cycles after the accept,
    // or one later if a window was due and win_ready was already high.
    task automatic send(input logic [DW-1:0] d, output int acc_cyc);
        bit got;
        bit due;
        got = 1'b0;
        acc_cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_within_budget", {31'b0, got}, 32'd1);
        if (!got) begin
            bus.in_valid = 1'b0;
            last_due = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        hist.push_back(d);
        @(negedge clk);
        chk("shift_en_pulse", {31'b0, bus.shift_en}, 32'd1);
        chk("shift_data", bus.shift_data, d);
        chk("in_ready_in_shift", {31'b0, bus.in_ready}, 32'd0);
        m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
        m_since++;
        due = (m_fill == DEPTH) && (m_first || (m_since == STRIDE));
        @(negedge clk);
        chk("fill", bus.fill, m_fill);
        chk("shift_en_low_after", {31'b0, bus.shift_en}, 32'd0);
        chk("win_valid", {31'b0, bus.win_valid}, {31'b0, due});
        if (due) begin
            check_window();
            m_first = 1'b0;
            m_since = 0;
            if (bus.win_ready) begin
                m_wins++;
                @(negedge clk);
                chk("win_valid_drop", {31'b0, bus.win_valid}, 32'd0);
                chk("win_cnt", bus.win_cnt, m_wins);
            end
        end
        last_due = due;
    endtask

    // Window pending with win_ready low: hold for h cycles with a sample
    // offered, then release and confirm the controller is ready again.
    task automatic release_window(input int h);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h99;
        for (int k = 0; k < h; k++) begin
            chk("hold_win_valid", {31'b0, bus.win_valid}, 32'd1);
            chk("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("hold_shift_en", {31'b0, bus.shift_en}, 32'd0);
            check_window();
            @(negedge clk);
        end
        bus.win_ready = 1'b1;
        bus.in_valid = 1'b0;
        m_wins++;
        @(negedge clk);
        chk("release_win_valid", {31'b0, bus.win_valid}, 32'd0);
        chk("release_win_cnt", bus.win_cnt, m_wins);
        chk("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int ac;
        int t0;
        int hold;
        for (int i = 0; i < DEPTH; i++) sr[i] = '0;
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.win_ready = 1'b1;

        // Reset values, during and after reset.
        #12;
        chk("rst_shift_en", {31'b0, bus.shift_en}, 32'd0);
        chk("rst_win_valid", {31'b0, bus.win_valid}, 32'd0);
        chk("rst_fill", bus.fill, 32'd0);
        chk("rst_win_cnt", bus.win_cnt, 32'd0);
        chk("rst_shift_data", bus.shift_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("post_rst_fill", bus.fill, 32'd0);

        // Fill to the first window; strobes every other cycle.
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            send(8'(8'h11 * (i + 1)), ac);
            chk("shift_cycle", ac - t0 + 1, 2 * i + 1);
        end
        chk("first_win_cnt", bus.win_cnt, 32'd1);

        // Stride of two after the first window.
        send(8'h55, ac);
        chk("no_win_after_55", {31'b0, last_due}, 32'd0);
        send(8'h66, ac);
        chk("win_after_66", bus.win_cnt, 32'd2);

        // Backpressure during PRESENT.
        bus.win_ready = 1'b0;
        send(8'h77, ac);
        send(8'h88, ac);
        chk("bp_window_due", {31'b0, last_due}, 32'd1);
        release_window(5);
        t0 = cyc;
        send(8'h90, ac);
        chk("bp_accept_resumes", ac, t0);

        // Clear during PRESENT, in the same cycle as win_ready.
        bus.win_ready = 1'b0;
        send(8'hA1, ac);
        chk("clear_setup_due", {31'b0, last_due}, 32'd1);
        bus.clear = 1'b1;
        bus.win_ready = 1'b1;
        @(posedge clk);
        #1 bus.clear = 1'b0;
        model_clear();
        @(negedge clk);
        chk("clear_win_valid", {31'b0, bus.win_valid}, 32'd0);
        chk("clear_fill", bus.fill, 32'd0);
        chk("clear_win_cnt_kept", bus.win_cnt, m_wins);
        chk("clear_in_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            send(8'(8'hB1 + i), ac);
            chk("refill_due", {31'b0, last_due}, {31'b0, i == 3});
        end

        // Clear together with in_valid in READY discards the sample.
        bus.in_valid = 1'b1;
        bus.in_data = 8'hC3;
        bus.clear = 1'b1;
        #1 chk("clear_blocks_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1 bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        chk("clear_no_shift", {31'b0, bus.shift_en}, 32'd0);
        chk("clear_shift_data_kept", bus.shift_data, hist[hist.size() - 1]);
        chk("clear_fill_again", bus.fill, 32'd0);

        // Randomized samples and consumer backpressure.
        for (int n = 0; n < 40; n++) begin
            hold = $urandom_range(0, 3);
            bus.win_ready = (hold == 0);
            send(8'($urandom), ac);
            if (last_due && hold != 0) release_window(hold);
            bus.win_ready = 1'b1;
        end

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = 8'hE5;
        chk("pre_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        #1 chk("mid_shift_strobe", {31'b0, bus.shift_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_shift_en", {31'b0, bus.shift_en}, 32'd0);
        chk("async_rst_fill", bus.fill, 32'd0);
        chk("async_rst_win_cnt", bus.win_cnt, 32'd0);
        chk("async_rst_shift_data", bus.shift_data, 32'd0);
        chk("async_rst_win_valid", {31'b0, bus.win_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("after_rst_shift_en", {31'b0, bus.shift_en}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
